// File: rtl/toggle_event_rx_pkg.sv
// Shared types and defaults for the toggle-event receiver.
// TOGGLE_EVENT_RX_GLITCH_FILTER_EN lengthens INIT by one edge to cover the filter stage.
package toggle_event_rx_pkg;

    typedef enum logic {INIT, RUN} rx_state_t;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 8;

    // Edges spent in INIT before the reference level is trusted.
    function automatic int unsigned init_edges(input int unsigned sync_stages);
`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
        return sync_stages + 1;
`else
        return sync_stages;
`endif
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for the toggle line, with an optional one-stage glitch
// filter selected by TOGGLE_EVENT_RX_GLITCH_FILTER_EN.
module toggle_sync
    import toggle_event_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tog_in,
    output logic level_o,
    output logic level_d_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    assign chain_d = {chain_q[SYNC_STAGES-2:0], tog_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
    logic filt_q;
    logic filt_d;

    // Accept a level only once the last stage has held it across two samples.
    assign filt_d = (chain_q[SYNC_STAGES-2] == chain_q[SYNC_STAGES-1]) ?
                    chain_q[SYNC_STAGES-1] : filt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign level_o   = filt_q;
    assign level_d_o = filt_d;
`else
    assign level_o   = chain_q[SYNC_STAGES-1];
    assign level_d_o = chain_q[SYNC_STAGES-2];
`endif

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-encoded event receiver: detects synchronised transitions and queues them
// as a saturating pending count. TOGGLE_EVENT_RX_GLITCH_FILTER_EN adds a glitch filter.
module toggle_event_rx
    import toggle_event_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow,
    output logic             armed
);

    localparam int unsigned      INIT_EDGES = init_edges(SYNC_STAGES);
    localparam int unsigned      INIT_W     = $clog2(INIT_EDGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    rx_state_t         state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              ref_q, ref_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              pulse_q, pulse_d;
    logic              level;
    logic              level_d;
    logic              inc;
    logic              dec;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .level_o   (level),
        .level_d_o (level_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ref_q      <= 1'b0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ref_q      <= ref_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ref_d      = ref_q;
        pulse_d    = 1'b0;
        inc        = 1'b0;
        pend_d     = pend_q;
        ovf_d      = ovf_q & ~clr_ovf;

        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                // Latch the level the synchroniser settles to on this edge so the
                // power-up level never shows up as an event.
                if (init_cnt_q == INIT_W'(INIT_EDGES - 1)) begin
                    ref_d   = level_d;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (level != ref_q) begin
                    ref_d   = level;
                    pulse_d = 1'b1;
                    inc     = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        dec = (pend_q != '0) & evt_ready;

        // Saturating count; an increment lost at the ceiling sets the sticky flag.
        if (inc && !dec) begin
            if (pend_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    assign evt_pulse = pulse_q;
    assign pend_cnt  = pend_q;
    assign overflow  = ovf_q;
    assign evt_valid = (pend_q != '0);
    assign armed     = (state_q == RUN);

endmodule

// File: doc/toggle_event_rx.md
Name: toggle_event_rx

Overview:
Receiver for toggle-encoded events. The transmitter is a T flip-flop driven with t=1 for one cycle per event, so every event flips its q. This block synchronises that toggling line into the local clock domain and detects each transition. It turns each transition back into a one-cycle pulse and queues the events as a pending count, which a consumer drains over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, flops in the input synchroniser chain (legal values ≥ 2).
CNT_W, 8, width of the pending-event counter; the counter saturates at 2**CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
tog_in  input  1  toggle line from the T-flip-flop transmitter; may be asynchronous to clk.
evt_ready  input  1  consumer accepts one event when evt_valid is also high.
clr_ovf  input  1  clears the sticky overflow flag.
evt_pulse  output  1  one-cycle pulse per detected transition.
evt_valid  output  1  high while pend_cnt != 0.
pend_cnt  output  CNT_W  number of events not yet consumed.
overflow  output  1  sticky flag: an event was lost at saturation.
armed  output  1  high in state RUN.

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1):
  - synchroniser chain cleared to 0; ref=0; state INIT; init counter=0.
  - Outputs: evt_pulse=0, pend_cnt=0, evt_valid=0, overflow=0, armed=0.
- Reset asserted mid-operation discards all pending events. Reset has priority over every other input.
- Synchroniser: tog_in passes through SYNC_STAGES flops. The last stage is sync_q.
- State INIT:
  - Counts SYNC_STAGES edges with reset=0 so the chain can fill.
  - On the last counting edge: ref <= sync_q and state -> RUN.
  - Transitions seen during INIT are absorbed into ref and never reported. No event is generated from the power-up level.
- State RUN:
  - Each edge, det = (sync_q != ref).
  - When det=1: ref <= sync_q, evt_pulse <= 1, and the event is counted. Otherwise evt_pulse <= 0.
  - RUN exits only through reset.
- Latency: tog_in changes and is stable at edge E0 → evt_pulse is high for exactly one cycle after edge E0+SYNC_STAGES. pend_cnt updates on the same edge.
- Throughput: at most one event per transition. Two tog_in flips within one sampling window cancel each other; this is a documented protocol limit. The transmitter must hold each level for ≥ SYNC_STAGES+1 clk cycles.
- Pending counter (inc = det in RUN, dec = evt_valid & evt_ready):
  - inc only: +1.
  - dec only: -1.
  - both in the same cycle: unchanged.
  - evt_ready while pend_cnt=0: ignored, no underflow.
- Saturation:
  - inc without dec while pend_cnt = 2**CNT_W-1: pend_cnt holds and overflow <= 1.
  - inc with dec at saturation: pend_cnt holds and no overflow is raised.
- overflow:
  - Sticky; cleared by reset or clr_ovf.
  - If clr_ovf and a new overflow occur in the same cycle, overflow stays 1 (set wins).
- evt_valid is combinational from the registered pend_cnt.

Optional Feature:
TOGGLE_EVENT_RX_GLITCH_FILTER_EN
- Defined:
  - Adds one stage after sync_q. A candidate level is accepted only when sync_q equals the previous sync_q sample (stable for 2 consecutive cycles). Single-cycle glitches are ignored.
  - Latency becomes SYNC_STAGES+1.
  - INIT lasts SYNC_STAGES+1 edges.
  - Minimum hold per level becomes SYNC_STAGES+2 cycles.
- Undefined: no filter; behaviour as described above.

Decomposition:
- Package toggle_event_rx_pkg holds:
  - typedef enum logic {INIT, RUN} rx_state_t;
  - localparam defaults for SYNC_STAGES and CNT_W.
- Sub-module: toggle_sync, a SYNC_STAGES-deep synchroniser with the optional glitch filter and a synchronous reset to 0.
- The top level holds the FSM, ref, the pending counter and overflow.

Test Plan:
1. Bench default is SYNC_STAGES=2. Reset, then hold tog_in=1 during INIT → no evt_pulse, armed=1 after 2 edges, pend_cnt=0.
2. In RUN, toggle tog_in 3 times with 6-cycle spacing and evt_ready=0 → 3 single-cycle evt_pulses, each 2 cycles after its flip; pend_cnt=3; evt_valid=1.
3. Then hold evt_ready=1 → pend_cnt goes 2, 1, 0 on successive edges, then evt_valid=0. A flip concurrent with a dec leaves pend_cnt unchanged.
4. CNT_W=2: issue 4 flips with no ready → pend_cnt=3, overflow=1. Pulse clr_ovf → overflow=0, pend_cnt stays 3.
5. Assert reset with pend_cnt=3 → next cycle pend_cnt=0, evt_valid=0, armed=0, overflow=0, and INIT repeats.
6. With TOGGLE_EVENT_RX_GLITCH_FILTER_EN defined, apply a 1-cycle tog_in glitch → no event. A stable flip → evt_pulse 3 cycles later.
